// File: rtl/word_assembler.sv
// Purpose : packs NUM_BEATS narrow stream beats into one wide word (beat 0 in LSBs); IN_LAST closes a short, zero-padded word.
// Latency : the word is registered on the edge that accepts the closing beat and is valid the following cycle.
// Backpres: only the closing beat stalls, and only while the output register is full and not draining; other beats always accepted.
// Option  : define WORD_ASSEMBLER_MSB_FIRST_EN to place beat 0 in the MSBs (short words become left-aligned).
module word_assembler #(
  parameter  int IN_WIDTH  = 8,
  parameter  int NUM_BEATS = 4,
  localparam int OUT_WIDTH = IN_WIDTH * NUM_BEATS,
  localparam int CNT_WIDTH = $clog2(NUM_BEATS + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [IN_WIDTH-1:0]  IN_DATA,
  input  logic                 IN_VALID,
  input  logic                 IN_LAST,
  output logic                 IN_READY,
  output logic [OUT_WIDTH-1:0] OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [CNT_WIDTH-1:0] OUT_COUNT,
  output logic                 OUT_SHORT
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(NUM_BEATS);

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] merged;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] slot;
  logic                 closing;
  logic                 accept;

  // A beat closes the word when it fills the last slot or carries IN_LAST.
  assign closing  = (cnt == LAST_IDX) || IN_LAST;
  // Only a closing beat needs room in the output register; a draining register counts as room.
  assign IN_READY = closing ? (!OUT_VALID || OUT_READY) : 1'b1;
  assign accept   = IN_VALID && IN_READY;
  assign cnt_inc  = cnt + 1'b1;

`ifdef WORD_ASSEMBLER_MSB_FIRST_EN
  assign slot = LAST_IDX - cnt;
`else
  assign slot = cnt;
`endif

  // Accumulator with the current beat dropped into its slot; unfilled slots are still zero.
  always_comb begin
    merged = acc;
    merged[int'(slot) * IN_WIDTH +: IN_WIDTH] = IN_DATA;
  end

  // Accumulate beats, load the output register on a closing beat, clear valid on a bare drain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc       <= '0;
      cnt       <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OUT_COUNT <= '0;
      OUT_SHORT <= 1'b0;
    end else begin
      if (OUT_VALID && OUT_READY) begin
        OUT_VALID <= 1'b0;
      end
      if (accept) begin
        if (closing) begin
          OUT_DATA  <= merged;
          OUT_COUNT <= cnt_inc;
          OUT_SHORT <= (cnt_inc != FULL_CNT);
          OUT_VALID <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
        end else begin
          acc <= merged;
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule
